seg7_shift_ctrl: RTL and testbench
==================================

Name: seg7_shift_ctrl

Overview:
Serial output controller for the board's 8-digit seven-segment display, which is driven through a 64-bit chain of external shift registers. It accepts a 64-bit segment word from the pixel/hex mapping stage over a valid/ready handshake and clocks the word out MSB-first on seg_clk/seg_dat. It then pulses seg_latch to transfer the word to the display outputs. An optional auto-refresh re-sends the last word periodically so the display recovers from glitches.

Parameters:
SEG_WIDTH, 64, bits per frame; equals the external shift-chain length.
DIV, 2, clk cycles per seg_clk half-period; legal range is 1 or more.
REFRESH_CYCLES, 0, idle clk cycles before the last word is re-sent; 0 disables auto-refresh.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
in_data  input  SEG_WIDTH  segment word; bit 63 is shifted first
in_valid  input  1  in_data is valid
in_ready  output  1  controller can accept a word; high exactly when state is IDLE
busy  output  1  transfer in progress (SHIFT or LATCH)
done  output  1  one-cycle pulse when a frame has been latched
seg_clk  output  1  shift clock to the chain; the external device samples on the rising edge
seg_dat  output  1  serial data
seg_latch  output  1  storage-register latch pulse, active-high
seg_clrn  output  1  chain clear, active-low

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high (rst). All outputs are registered except in_ready, which is decoded from state.
- Reset values: state IDLE, seg_clk 0, seg_dat 0, seg_latch 0, busy 0, done 0, shadow register 0, refresh counter 0, "have_word" flag 0.
- seg_clrn is 0 during any cycle following a clock edge with rst=1, and 1 otherwise.
- Reset mid-transfer aborts the frame immediately. Nothing is latched and no done pulse is produced.
- States:
  - IDLE
    - in_valid & in_ready: capture in_data into the shadow register, set have_word, go to SHIFT. This is the handshake cycle, cycle 0.
    - Refresh: if REFRESH_CYCLES>0, have_word=1 and the refresh counter reaches REFRESH_CYCLES-1, go to SHIFT with the existing shadow register.
    - A new handshake in the same cycle as a refresh expiry wins and loads the new data.
  - SHIFT: bit index runs 63 down to 0.
    - Per bit: seg_dat = shadow[idx] and seg_clk=0 for DIV cycles, then seg_clk=1 for DIV cycles.
    - seg_dat is stable for the whole 2*DIV window, so setup and hold are each at least DIV cycles.
    - After the high phase of bit 0, go to LATCH. Total SHIFT time is SEG_WIDTH*2*DIV cycles.
  - LATCH: seg_clk=0, seg_latch=1 for DIV cycles, then go to IDLE. done=1 for the first cycle back in IDLE, and the refresh counter clears.
- Latency with DIV=2: handshake at cycle 0, SHIFT in cycles 1..256, LATCH in cycles 257..258, done and in_ready both high in cycle 259. Back-to-back words are accepted in cycle 259.
- in_data changes after the handshake are ignored; the transfer uses the captured copy.
- in_valid while busy: in_ready=0, so there is no capture. The requester must hold in_valid.
- The refresh counter runs only in IDLE with have_word=1. It saturates and does not wrap.
- The DIV phase counter and bit index are sized with $clog2. The bit index stops at 0 and does not wrap.

Decomposition:
- Shared package seg7_pkg holds:
  - the SEG_WIDTH=64 constant;
  - the state enum (IDLE, SHIFT, LATCH);
  - the digit/segment bit-position constants used by the mapping stage.
- One sub-module, seg7_tick_gen: the DIV phase counter. It emits a one-cycle tick at each seg_clk half-period boundary while enabled, and resets to 0 when enable is low.

Test Plan:
1. Reset, DIV=2, REFRESH_CYCLES=0 -> after the rst edge: in_ready=1, seg_clrn=1, seg_clk=0, seg_latch=0, done=0.
2. Send in_data=64'hA5A5_0000_FFFF_0123 -> 64 rising seg_clk edges. The sampled seg_dat sequence equals bits 63..0 of the word. seg_latch is high in cycles 257-258, done in cycle 259.
3. Send a word, then change in_data and hold in_valid=1 during the transfer -> in_ready stays 0 until cycle 259. The first frame carries the original word; the second handshake occurs in cycle 259 and shifts the new word.
4. rst asserted at cycle 100 of a transfer -> seg_clrn=0 and state IDLE after the next edge. No seg_latch pulse and no done pulse.
5. REFRESH_CYCLES=10, send one word, then hold in_valid=0 -> an identical frame restarts 10 cycles after done. Repeat this check with in_valid asserted on the expiry cycle: the new word must be shifted.
6. DIV=1 -> the seg_clk period is 2 clk cycles and the full frame takes 129 cycles from handshake to first LATCH cycle exit (done in cycle 130).

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment serial output path.
// Bit-position constants describe how the mapping stage packs digits into a frame.
package seg7_pkg;

    localparam int SEG_WIDTH      = 64;
    localparam int NUM_DIGITS     = 8;
    localparam int SEGS_PER_DIGIT = 8;

    // Segment positions within one digit byte; the highest byte holds digit 7.
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } state_t;

    function automatic int digit_base(input int digit);
        return digit * SEGS_PER_DIGIT;
    endfunction

endpackage

// File: rtl/seg7_shift_ctrl_if.sv
// Valid/ready handshake carrying one segment frame from the mapping stage.
interface seg7_shift_ctrl_if #(
    parameter int WIDTH = seg7_pkg::SEG_WIDTH
) ();

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/seg7_tick_gen.sv
// Phase counter that marks each seg_clk half-period boundary while enabled.
module seg7_tick_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] phase;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            phase <= '0;
        end else if (phase == LAST) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

    assign tick = en && (phase == LAST);

endmodule

// File: rtl/seg7_shift_ctrl.sv
// Shifts a captured segment frame MSB-first into the external register chain,
// latches it, and optionally re-sends the last frame after an idle period.
module seg7_shift_ctrl #(
    parameter int SEG_WIDTH      = seg7_pkg::SEG_WIDTH,
    parameter int DIV            = 2,
    parameter int REFRESH_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    seg7_shift_ctrl_if.slave bus,
    output logic             busy,
    output logic             done,
    output logic             seg_clk,
    output logic             seg_dat,
    output logic             seg_latch,
    output logic             seg_clrn
);

    import seg7_pkg::*;

    localparam int            IW       = $clog2(SEG_WIDTH);
    localparam int            RW       = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [RW-1:0] REF_LAST = RW'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_TOP  = IW'(SEG_WIDTH - 1);

    state_t               state;
    state_t               state_nxt;
    logic [SEG_WIDTH-1:0] shadow;
    logic [SEG_WIDTH-1:0] shadow_nxt;
    logic [IW-1:0]        idx;
    logic [IW-1:0]        idx_nxt;
    logic [IW-1:0]        idx_dec;
    logic                 have_word;
    logic                 have_word_nxt;
    logic [RW-1:0]        refresh_cnt;
    logic                 clk_nxt;
    logic                 dat_nxt;
    logic                 tick;
    logic                 accept;
    logic                 refresh_due;
    logic                 last_bit;

    seg7_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (state != IDLE),
        .tick (tick)
    );

    assign accept      = (state == IDLE) && bus.in_valid;
    assign refresh_due = (REFRESH_CYCLES > 0) && have_word && (state == IDLE)
                         && (refresh_cnt == REF_LAST);
    assign last_bit    = (idx == '0);
    assign idx_dec     = idx - 1'b1;
    assign bus.in_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Each bit ends on the tick that closes its high phase.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept || refresh_due) state_nxt = SHIFT;
            SHIFT:   if (tick && seg_clk && last_bit) state_nxt = LATCH;
            LATCH:   if (tick) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        shadow_nxt    = shadow;
        have_word_nxt = have_word;
        idx_nxt       = idx;
        clk_nxt       = seg_clk;
        dat_nxt       = seg_dat;
        case (state)
            IDLE: begin
                clk_nxt = 1'b0;
                idx_nxt = IDX_TOP;
                if (accept) begin
                    shadow_nxt    = bus.in_data;
                    have_word_nxt = 1'b1;
                    dat_nxt       = bus.in_data[SEG_WIDTH-1];
                end else if (refresh_due) begin
                    dat_nxt = shadow[SEG_WIDTH-1];
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (!seg_clk) begin
                        clk_nxt = 1'b1;
                    end else begin
                        clk_nxt = 1'b0;
                        if (!last_bit) begin
                            idx_nxt = idx_dec;
                            dat_nxt = shadow[idx_dec];
                        end
                    end
                end
            end
            default: clk_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow      <= '0;
            have_word   <= 1'b0;
            idx         <= '0;
            refresh_cnt <= '0;
            seg_clk     <= 1'b0;
            seg_dat     <= 1'b0;
            seg_latch   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            seg_clrn    <= 1'b0;
        end else begin
            shadow    <= shadow_nxt;
            have_word <= have_word_nxt;
            idx       <= idx_nxt;
            seg_clk   <= clk_nxt;
            seg_dat   <= dat_nxt;
            seg_latch <= (state_nxt == LATCH);
            busy      <= (state_nxt != IDLE);
            done      <= (state == LATCH) && (state_nxt == IDLE);
            seg_clrn  <= 1'b1;
            // Counts idle time only; any transfer restarts the refresh interval.
            if (state != IDLE) begin
                refresh_cnt <= '0;
            end else if (have_word && (refresh_cnt != REF_LAST)) begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_shift_ctrl.sv
// Directed bench for seg7_shift_ctrl: three instances cover DIV=2, refresh, and DIV=1.
module tb_seg7_shift_ctrl;

    logic        clk;
    logic        rst_a, rst_r, rst_d;
    logic [63:0] drv_data;
    logic        drv_valid;
    int          sel;
    int          assertCount;
    int          failCount;

    logic busy_a, done_a, sclk_a, sdat_a, slat_a, clrn_a;
    logic busy_r, done_r, sclk_r, sdat_r, slat_r, clrn_r;
    logic busy_d, done_d, sclk_d, sdat_d, slat_d, clrn_d;

    logic obs_busy, obs_done, obs_seg_clk, obs_seg_dat, obs_seg_latch, obs_seg_clrn, obs_in_ready;

    seg7_shift_ctrl_if #(.WIDTH(64)) bus_a ();
    seg7_shift_ctrl_if #(.WIDTH(64)) bus_r ();
    seg7_shift_ctrl_if #(.WIDTH(64)) bus_d ();

    assign bus_a.in_data  = drv_data;
    assign bus_r.in_data  = drv_data;
    assign bus_d.in_data  = drv_data;
    assign bus_a.in_valid = drv_valid && (sel == 0);
    assign bus_r.in_valid = drv_valid && (sel == 1);
    assign bus_d.in_valid = drv_valid && (sel == 2);

    seg7_shift_ctrl #(.SEG_WIDTH(64), .DIV(2), .REFRESH_CYCLES(0)) dut_a (
        .clk (clk), .rst (rst_a), .bus (bus_a), .busy (busy_a), .done (done_a),
        .seg_clk (sclk_a), .seg_dat (sdat_a), .seg_latch (slat_a), .seg_clrn (clrn_a)
    );

    seg7_shift_ctrl #(.SEG_WIDTH(64), .DIV(2), .REFRESH_CYCLES(10)) dut_r (
        .clk (clk), .rst (rst_r), .bus (bus_r), .busy (busy_r), .done (done_r),
        .seg_clk (sclk_r), .seg_dat (sdat_r), .seg_latch (slat_r), .seg_clrn (clrn_r)
    );

    seg7_shift_ctrl #(.SEG_WIDTH(64), .DIV(1), .REFRESH_CYCLES(0)) dut_d (
        .clk (clk), .rst (rst_d), .bus (bus_d), .busy (busy_d), .done (done_d),
        .seg_clk (sclk_d), .seg_dat (sdat_d), .seg_latch (slat_d), .seg_clrn (clrn_d)
    );

    always_comb begin
        obs_busy      = busy_a;
        obs_done      = done_a;
        obs_seg_clk   = sclk_a;
        obs_seg_dat   = sdat_a;
        obs_seg_latch = slat_a;
        obs_seg_clrn  = clrn_a;
        obs_in_ready  = bus_a.in_ready;
        if (sel == 1) begin
            obs_busy      = busy_r;
            obs_done      = done_r;
            obs_seg_clk   = sclk_r;
            obs_seg_dat   = sdat_r;
            obs_seg_latch = slat_r;
            obs_seg_clrn  = clrn_r;
            obs_in_ready  = bus_r.in_ready;
        end else if (sel == 2) begin
            obs_busy      = busy_d;
            obs_done      = done_d;
            obs_seg_clk   = sclk_d;
            obs_seg_dat   = sdat_d;
            obs_seg_latch = slat_d;
            obs_seg_clrn  = clrn_d;
            obs_in_ready  = bus_d.in_ready;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [63:0] data);
        drv_valid = valid;
        drv_data  = data;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Called in cycle 0 (handshake or refresh expiry); returns in the done cycle.
    task automatic monitorFrame(input string tag, input logic [63:0] expWord, input int div,
                                input bit stress, input logic [63:0] lateData);
        int          frameLen;
        int          doneCyc;
        int          rises;
        int          firstLatch;
        int          latchCnt;
        int          doneAt;
        int          readyEarly;
        int          busyBad;
        logic [63:0] captured;
        logic        prevClk;
        frameLen   = 64 * 2 * div;
        doneCyc    = frameLen + div + 1;
        rises      = 0;
        firstLatch = -1;
        latchCnt   = 0;
        doneAt     = -1;
        readyEarly = 0;
        busyBad    = 0;
        captured   = '0;
        prevClk    = obs_seg_clk;
        for (int cyc = 1; cyc <= doneCyc; cyc++) begin
            stepCycle();
            if (cyc == 1) begin
                if (stress) drv_data = lateData;
                else drv_valid = 1'b0;
            end
            if (obs_seg_clk && !prevClk) begin
                captured = {captured[62:0], obs_seg_dat};
                rises++;
            end
            prevClk = obs_seg_clk;
            if (obs_seg_latch) begin
                if (firstLatch < 0) firstLatch = cyc;
                latchCnt++;
            end
            if (obs_done && doneAt < 0) doneAt = cyc;
            if (obs_in_ready && cyc < doneCyc) readyEarly++;
            if (obs_busy != (cyc < doneCyc)) busyBad++;
        end
        checkOutput({tag, " word"}, captured, expWord);
        checkOutput({tag, " rises"}, 64'(rises), 64'd64);
        checkOutput({tag, " latch_start"}, 64'(firstLatch), 64'(frameLen + 1));
        checkOutput({tag, " latch_len"}, 64'(latchCnt), 64'(div));
        checkOutput({tag, " done_cycle"}, 64'(doneAt), 64'(doneCyc));
        checkOutput({tag, " ready_early"}, 64'(readyEarly), 64'd0);
        checkOutput({tag, " busy_profile"}, 64'(busyBad), 64'd0);
        checkOutput({tag, " ready_at_done"}, 64'(obs_in_ready), 64'd1);
    endtask

    initial begin
        int latchSeen;
        int doneSeen;
        int busySeen;
        assertCount = 0;
        failCount   = 0;
        sel         = 0;
        rst_a       = 1'b1;
        rst_r       = 1'b1;
        rst_d       = 1'b1;
        applyStimulus(1'b0, 64'h0);
        stepCycle();
        stepCycle();

        // Reset state on the DIV=2 instance.
        checkOutput("rst clrn_low", 64'(obs_seg_clrn), 64'd0);
        rst_a = 1'b0;
        rst_r = 1'b0;
        rst_d = 1'b0;
        stepCycle();
        checkOutput("rst in_ready", 64'(obs_in_ready), 64'd1);
        checkOutput("rst clrn_high", 64'(obs_seg_clrn), 64'd1);
        checkOutput("rst seg_clk", 64'(obs_seg_clk), 64'd0);
        checkOutput("rst seg_latch", 64'(obs_seg_latch), 64'd0);
        checkOutput("rst done", 64'(obs_done), 64'd0);
        checkOutput("rst busy", 64'(obs_busy), 64'd0);

        // Basic frame.
        applyStimulus(1'b1, 64'hA5A5_0000_FFFF_0123);
        checkOutput("t2 ready_c0", 64'(obs_in_ready), 64'd1);
        monitorFrame("t2", 64'hA5A5_0000_FFFF_0123, 2, 1'b0, 64'h0);
        stepCycle();
        checkOutput("t2 done_pulse", 64'(obs_done), 64'd0);

        // Data changed and valid held during the transfer; back-to-back accept.
        applyStimulus(1'b1, 64'h0123_4567_89AB_CDEF);
        monitorFrame("t3a", 64'h0123_4567_89AB_CDEF, 2, 1'b1, 64'hFEDC_BA98_7654_3210);
        checkOutput("t3 valid_held", 64'(drv_valid), 64'd1);
        monitorFrame("t3b", 64'hFEDC_BA98_7654_3210, 2, 1'b0, 64'h0);

        // Reset at cycle 100 of a transfer.
        stepCycle();
        applyStimulus(1'b1, 64'hDEAD_BEEF_0000_FFFF);
        stepCycle();
        drv_valid = 1'b0;
        for (int c = 2; c <= 100; c++) stepCycle();
        checkOutput("t4 busy_c100", 64'(obs_busy), 64'd1);
        rst_a = 1'b1;
        stepCycle();
        rst_a = 1'b0;
        checkOutput("t4 clrn", 64'(obs_seg_clrn), 64'd0);
        checkOutput("t4 in_ready", 64'(obs_in_ready), 64'd1);
        checkOutput("t4 busy", 64'(obs_busy), 64'd0);
        checkOutput("t4 seg_clk", 64'(obs_seg_clk), 64'd0);
        latchSeen = 0;
        doneSeen  = 0;
        for (int c = 0; c < 300; c++) begin
            stepCycle();
            if (obs_seg_latch) latchSeen++;
            if (obs_done) doneSeen++;
        end
        checkOutput("t4 no_latch", 64'(latchSeen), 64'd0);
        checkOutput("t4 no_done", 64'(doneSeen), 64'd0);
        checkOutput("t4 clrn_after", 64'(obs_seg_clrn), 64'd1);

        // Auto-refresh on the REFRESH_CYCLES=10 instance.
        sel = 1;
        stepCycle();
        applyStimulus(1'b1, 64'h1357_9BDF_2468_ACE0);
        monitorFrame("t5 first", 64'h1357_9BDF_2468_ACE0, 2, 1'b0, 64'h0);
        busySeen = 0;
        for (int c = 1; c <= 9; c++) begin
            stepCycle();
            if (obs_busy) busySeen++;
        end
        checkOutput("t5 idle_gap", 64'(busySeen), 64'd0);
        monitorFrame("t5 refresh", 64'h1357_9BDF_2468_ACE0, 2, 1'b0, 64'h0);
        for (int c = 1; c <= 9; c++) stepCycle();
        checkOutput("t5 ready_expiry", 64'(obs_in_ready), 64'd1);
        applyStimulus(1'b1, 64'h0F0F_F0F0_3C3C_C3C3);
        monitorFrame("t5 expiry_new", 64'h0F0F_F0F0_3C3C_C3C3, 2, 1'b0, 64'h0);

        // DIV=1 instance.
        sel = 2;
        stepCycle();
        applyStimulus(1'b1, 64'h8000_0000_0000_0001);
        monitorFrame("t6", 64'h8000_0000_0000_0001, 1, 1'b0, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
